spi_master_arbiter: RTL

- Shares one spi_master_4byte instance between R independent requesters.
- Round-robin arbitration across requesters.
- Latches the winner's command, slave-select target and CPOL/CPHA mode, then sequences the master's trigger/valid handshake.
- Returns the received word with a one-cycle ack; sits between the command sources (programmers, sensor pollers) and the SPI master.

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_arb_rr_grant.sv | 47 ++++
 rtl/spi_master_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI master arbiter.
package spi_arb_pkg;

    localparam int N_DEF         = 10;
    localparam int C_DEF         = 16;
    localparam int TO_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESPOND   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/spi_arb_rr_grant.sv
// Round-robin grant: searches upward from the pointer with wrap; the pointer
// moves past the served requester when adv_i is high. Reusable for any shared bus.
module spi_rr_grant #(
    parameter int R  = 4,
    parameter int IW = $clog2(R)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [R-1:0]  req_i,
    input  logic          adv_i,
    input  logic [IW-1:0] adv_idx_i,
    output logic [R-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   j;

    // Walk offsets high to low so the closest set bit above the pointer wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        j         = 0;
        for (int k = R - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % R;
            if (req_i[j]) begin
                gnt_o     = '0;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
                any_o     = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i)
            ptr_d = (adv_idx_i == IW'(R - 1)) ? '0 : adv_idx_i + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin front end sharing one spi_master_4byte between R requesters.
// Optional master watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int R         = 4,
    parameter int N         = N_DEF,
    parameter int C         = C_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic           CLK_IN,
    input  logic           RST_N,
    input  logic [R-1:0]   req,
    input  logic [R*C-1:0] req_din,
    input  logic [R*N-1:0] req_target,
    input  logic [R-1:0]   req_cpol,
    input  logic [R-1:0]   req_cpha,
    output logic [R-1:0]   ack,
    output logic [C-1:0]   rsp_dout,
    output logic           rsp_err,
    output logic           busy,
    output logic [C-1:0]   din,
    output logic [N-1:0]   target,
    output logic           trigger,
    output logic           CPOL,
    output logic           CPHA,
    input  logic [C-1:0]   dout,
    input  logic           valid
);
    localparam int IW = $clog2(R);

    arb_state_e    state_q;
    logic [R-1:0]  gnt, gnt_q, ack_q;
    logic [IW-1:0] gnt_idx, gidx_q;
    logic          any_req, can_grant, to_fire;
    logic [C-1:0]  din_q, rsp_dout_q;
    logic [N-1:0]  target_q;
    logic          rsp_err_q, busy_q, trig_q, cpol_q, cpha_q;

    spi_rr_grant #(.R(R), .IW(IW)) u_rr (
        .clk_i     (CLK_IN),
        .rst_ni    (RST_N),
        .req_i     (req),
        .adv_i     (state_q == ST_RESPOND),
        .adv_idx_i (gidx_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_req)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          stale_q, stale_d;
    logic          waiting;

    assign waiting   = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
    assign to_fire   = waiting && (to_cnt_q == TW'(TO_CYCLES - 1));
    assign can_grant = !stale_q;

    // After a timeout the master may still be mid-transfer; hold off new
    // grants until it reports idle so its late valid is not taken as ours.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == ST_LAUNCH) to_cnt_d = '0;
        else if (waiting)         to_cnt_d = to_cnt_q + 1'b1;
        stale_d = stale_q;
        if (to_fire)                           stale_d = 1'b1;
        else if (state_q == ST_IDLE && valid)  stale_d = 1'b0;
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            to_cnt_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            stale_q  <= stale_d;
        end
    end
`else
    assign to_fire   = 1'b0;
    assign can_grant = 1'b1;
`endif

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            ack_q      <= '0;
            rsp_dout_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            din_q      <= '0;
            target_q   <= '0;
            trig_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            ack_q  <= '0;
            trig_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req && can_grant) begin
                        gnt_q    <= gnt;
                        gidx_q   <= gnt_idx;
                        din_q    <= req_din[int'(gnt_idx)*C +: C];
                        target_q <= req_target[int'(gnt_idx)*N +: N];
                        cpol_q   <= req_cpol[gnt_idx];
                        cpha_q   <= req_cpha[gnt_idx];
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                // CPOL/CPHA have been on the bus one cycle here; an empty
                // slave mask is answered with an error and never launched.
                ST_SETUP: begin
                    if (target_q == '0) begin
                        rsp_err_q <= 1'b1;
                        ack_q     <= gnt_q;
                        state_q   <= ST_RESPOND;
                    end else begin
                        trig_q  <= 1'b1;
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state_q <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (to_fire) begin
                        rsp_dout_q <= '0;
                        rsp_err_q  <= 1'b1;
                        ack_q      <= gnt_q;
                        state_q    <= ST_RESPOND;
                    end else if (!valid) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (to_fire) begin
                        rsp_dout_q <= '0;
                        rsp_err_q  <= 1'b1;
                        ack_q      <= gnt_q;
                        state_q    <= ST_RESPOND;
                    end else if (valid) begin
                        rsp_dout_q <= dout;
                        rsp_err_q  <= 1'b0;
                        ack_q      <= gnt_q;
                        state_q    <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign rsp_dout = rsp_dout_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = busy_q;
    assign din      = din_q;
    assign target   = target_q;
    assign trigger  = trig_q;
    assign CPOL     = cpol_q;
    assign CPHA     = cpha_q;

endmodule
